// File: rtl/mux_scan_sequencer.sv
// Upstream driver/checker for a 16:1 mux tree: drives one word on D, sweeps S 0..15 and
// rebuilds the word from one mux output. Optional out_par output: define MUX_SCAN_PARITY_EN.
module mux_scan_sequencer #(
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MODE   = 0,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] dat,
    input  logic              m2,
    input  logic              m4,
    input  logic              m8,
    input  logic              m16,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              out_par
`endif
);

    // Out-of-range MODE falls back to the full 16-lane (M16) check.
    localparam int unsigned      LANES       = (MODE <= 3) ? (DATA_W >> MODE) : DATA_W;
    localparam logic [SEL_W-1:0] LANE_MASK   = SEL_W'(LANES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(DATA_W - 1);
    localparam logic [2:0]       SETTLE_LAST = 3'((SETTLE > 1) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] dat_q;
    logic [2:0]        cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] cap_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_err_q;

    logic chk_bit;
    logic exp_bit;
    logic accept;
    logic unused_mux;

    generate
        case (MODE)
            1:       begin : g_m8  assign chk_bit = m8;  end
            2:       begin : g_m4  assign chk_bit = m4;  end
            3:       begin : g_m2  assign chk_bit = m2;  end
            default: begin : g_m16 assign chk_bit = m16; end
        endcase
    endgenerate

    assign unused_mux = &{1'b0, m2, m4, m8, m16};
    assign exp_bit    = dat_q[sel_q & LANE_MASK];
    assign accept     = in_valid && (state_q == S_IDLE);

    for (genvar i = 0; i < DATA_W; i++) begin : g_cap
        // NOTE: capture bits are plain flops, so they are reset; an abandoned sweep must not leak partial bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cap_q[i] <= 1'b0;
            end else if (accept) begin
                cap_q[i] <= 1'b0;
            end else if (state_q == S_SAMPLE && sel_q == SEL_W'(i)) begin
                cap_q[i] <= chk_bit;
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic out_par_q;
`endif

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dat_q   <= in_data;
                        sel_q   <= '0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_DRIVE;
                    end
                end
                // DRIVE lasts at least one cycle, so SETTLE=0 and SETTLE=1 time identically.
                S_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_SAMPLE: begin
                    if (chk_bit != exp_bit) begin
                        err_q <= 1'b1;
                    end
                    if (sel_q == SEL_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        sel_q   <= sel_q + 1'b1;
                        state_q <= S_DRIVE;
                    end
                end
                // First DONE cycle publishes the result, since the last capture bit lands on DONE entry.
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= cap_q;
                        out_err_q   <= err_q;
`ifdef MUX_SCAN_PARITY_EN
                        out_par_q   <= ^cap_q;
`endif
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign sel       = sel_q;
    assign dat       = dat_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
`ifdef MUX_SCAN_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (M16/SETTLE=1 and M4/SETTLE=2) driven by a
// behavioural mux-tree model with fault injection; results checked against a word-level reference.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]       in_valid, in_ready, out_valid, out_ready, out_err, stuck;
    logic [1:0]       m2, m4, m8, m16;
    logic [1:0][15:0] in_data, dat, out_data, flip;
    logic [1:0][3:0]  sel;
`ifdef MUX_SCAN_PARITY_EN
    logic [1:0]       out_par;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Mux tree under test: ideal outputs, optional stuck-at-0 on M16 and per-select bit flips.
    for (genvar k = 0; k < 2; k++) begin : g_mux
        assign m16[k] = (dat[k][sel[k]] & ~stuck[k]) ^ flip[k][sel[k]];
        assign m8[k]  = dat[k][sel[k][2:0]] ^ flip[k][sel[k]];
        assign m4[k]  = dat[k][sel[k][1:0]] ^ flip[k][sel[k]];
        assign m2[k]  = dat[k][sel[k][0]] ^ flip[k][sel[k]];
    end

    mux_scan_sequencer #(.SEL_W(4), .DATA_W(16), .MODE(0), .SETTLE(1)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .sel       (sel[0]),
        .dat       (dat[0]),
        .m2        (m2[0]),
        .m4        (m4[0]),
        .m8        (m8[0]),
        .m16       (m16[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .out_err   (out_err[0])
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_par   (out_par[0])
`endif
    );

    mux_scan_sequencer #(.SEL_W(4), .DATA_W(16), .MODE(2), .SETTLE(2)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .sel       (sel[1]),
        .dat       (dat[1]),
        .m2        (m2[1]),
        .m4        (m4[1]),
        .m8        (m8[1]),
        .m16       (m16[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .out_err   (out_err[1])
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_par   (out_par[1])
`endif
    );

    function automatic int mode_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Word the checker should expect if the mux were perfect: bit i = D[i mod N].
    function automatic logic [15:0] ideal_word(input logic [15:0] w, input int mode);
        logic [15:0] r;
        int n;
        n = 16 >> mode;
        for (int i = 0; i < 16; i++) r[i] = w[i % n];
        return r;
    endfunction

    // Word the checker actually observes through the faulty mux.
    function automatic logic [15:0] seen_word(input logic [15:0] w, input int mode,
                                              input logic [15:0] f, input logic s);
        logic [15:0] r;
        logic [15:0] base;
        base = ideal_word(w, mode);
        for (int i = 0; i < 16; i++) r[i] = ((s && mode == 0) ? 1'b0 : base[i]) ^ f[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_word(input int k, input logic [15:0] w, input logic [15:0] f, input logic s);
        flip[k]     = f;
        stuck[k]    = s;
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        check("accept_ready", 32'(in_ready[k]), 32'd1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        check("accept_dat", 32'(dat[k]), 32'(w));
        check("accept_sel", 32'(sel[k]), 32'd0);
    endtask

    task automatic wait_result(input int k, input string tag, input logic [15:0] w,
                               input logic [15:0] f, input logic s);
        logic [15:0] exp_data;
        int cyc;
        exp_data = seen_word(w, mode_of(k), f, s);
        cyc = 0;
        while (out_valid[k] !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(1 + 16 * (settle_of(k) + 1)));
        check({tag, "_data"}, 32'(out_data[k]), 32'(exp_data));
        check({tag, "_err"}, 32'(out_err[k]), 32'(exp_data != ideal_word(w, mode_of(k))));
        check({tag, "_sel15"}, 32'(sel[k]), 32'd15);
`ifdef MUX_SCAN_PARITY_EN
        check({tag, "_par"}, 32'(out_par[k]), 32'(^exp_data));
`endif
    endtask

    task automatic release_result(input int k, input string tag, input int hold);
        logic [15:0] held;
        held = out_data[k];
        out_ready[k] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_hold_valid"}, 32'(out_valid[k]), 32'd1);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check({tag, "_rel_valid"}, 32'(out_valid[k]), 32'd0);
        check({tag, "_rel_ready"}, 32'(in_ready[k]), 32'd1);
        check({tag, "_rel_data"}, 32'(out_data[k]), 32'(held));
    endtask

    initial begin
        int cyc;
        logic [15:0] w;
        logic [15:0] f;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        stuck     = '0;
        in_data   = '0;
        flip      = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 32'(sel[0]), 32'd0);
        check("rst_dat", 32'(dat[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-sweep at sel=7
        accept_word(0, 16'hBEEF, 16'h0, 1'b0);
        cyc = 0;
        while (sel[0] !== 4'd7 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid_reach_sel7", 32'(sel[0]), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(sel[0]), 32'd0);
        check("mid_rst_dat", 32'(dat[0]), 32'd0);
        check("mid_rst_valid", 32'(out_valid[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready[0]), 32'd1);
        check("post_rst_sel", 32'(sel[0]), 32'd0);
        check("post_rst_dat", 32'(dat[0]), 32'd0);
        check("post_rst_out_data", 32'(out_data[0]), 32'd0);
        check("post_rst_out_err", 32'(out_err[0]), 32'd0);

        // Ideal M16 scan
        accept_word(0, 16'hA5C3, 16'h0, 1'b0);
        wait_result(0, "a5c3", 16'hA5C3, 16'h0, 1'b0);
        release_result(0, "a5c3", 0);

        // M16 stuck-at-0
        accept_word(0, 16'hFFFF, 16'h0, 1'b1);
        wait_result(0, "stuck", 16'hFFFF, 16'h0, 1'b1);
        release_result(0, "stuck", 1);
        stuck[0] = 1'b0;

        // M4 replicates D[3:0] across all 16 selects
        accept_word(1, 16'h000F, 16'h0, 1'b0);
        wait_result(1, "m4", 16'h000F, 16'h0, 1'b0);
        release_result(1, "m4", 0);

        // Parity word (odd count of ones)
        accept_word(0, 16'h0007, 16'h0, 1'b0);
        wait_result(0, "par7", 16'h0007, 16'h0, 1'b0);
        release_result(0, "par7", 0);

        // Back-pressure in DONE with a new word waiting
        accept_word(0, 16'h5A5A, 16'h0, 1'b0);
        wait_result(0, "hold", 16'h5A5A, 16'h0, 1'b0);
        in_data[0]   = 16'h1234;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid[0]), 32'd1);
            check("hold_data", 32'(out_data[0]), 32'h5A5A);
            check("hold_in_ready", 32'(in_ready[0]), 32'd0);
            check("hold_dat", 32'(dat[0]), 32'h5A5A);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("hs_valid", 32'(out_valid[0]), 32'd0);
        check("hs_in_ready", 32'(in_ready[0]), 32'd1);
        check("hs_data_kept", 32'(out_data[0]), 32'h5A5A);
        check("hs_dat_kept", 32'(dat[0]), 32'h5A5A);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("next_accept_ready", 32'(in_ready[0]), 32'd0);
        check("next_accept_dat", 32'(dat[0]), 32'h1234);
        wait_result(0, "hold2", 16'h1234, 16'h0, 1'b0);
        release_result(0, "hold2", 2);

        // Randomized words with random per-select faults on both instances
        for (int r = 0; r < 12; r++) begin
            w = 16'($urandom);
            f = ($urandom_range(0, 1) == 1) ? (16'($urandom) & 16'($urandom)) : 16'h0;
            accept_word(r % 2, w, f, 1'b0);
            wait_result(r % 2, "rand", w, f, 1'b0);
            release_result(r % 2, "rand", int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
